pipe_stage_elastic: RTL and testbench

- Parametrised, flow-controlled successor to the fixed EX/MEM latch.
- Carries a generic data bus and a control bus between any two CPU pipeline stages (EX/MEM, MEM/WB, IF/ID).
- Adds a valid/ready handshake, a 2-entry skid buffer, flush with control clearing, and occupancy reporting.
- Downstream stalls therefore never need a combinational ready path back through the stage.

---
 rtl/cpu_pipe_pkg.sv | 29 ++
 rtl/pipe_stage_elastic.sv | 130 +++++++++++++
 tb/tb_pipe_stage_elastic.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for elastic CPU pipeline stages: state encoding, bubble
// control value and the default control-field layout used to build in_ctrl.
package cpu_pipe_pkg;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
    localparam logic [ST_W-1:0] ST_ONE   = 2'd1;
    localparam logic [ST_W-1:0] ST_FULL  = 2'd2;

    localparam int unsigned CTRL_DEFAULT_W = 8;
    localparam logic [CTRL_DEFAULT_W-1:0] CTRL_RST_DEFAULT = '0;

    // Bit offsets into the default 8-bit control payload
    localparam int unsigned CTRL_REG_WRITE  = 0;
    localparam int unsigned CTRL_MEM_READ   = 1;
    localparam int unsigned CTRL_MEM_WRITE  = 2;
    localparam int unsigned CTRL_MEM_TO_REG = 3;
    localparam int unsigned CTRL_RD_LSB     = 4;
    localparam int unsigned CTRL_RD_W       = 4;

    typedef struct packed {
        logic [CTRL_RD_W-1:0] rd_addr;
        logic                 mem_to_reg;
        logic                 mem_write;
        logic                 mem_read;
        logic                 reg_write;
    } ctrl_t;

endpackage

// File: rtl/pipe_stage_elastic.sv
// Flow-controlled pipeline register with optional 2-entry skid buffer, flush
// and occupancy. With SKID_EN = 0, in_ready depends combinationally on out_ready.
module pipe_stage_elastic
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_RST_DEFAULT),
    parameter bit                SKID_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_nxt;
    logic              rdy_q;
    logic              accept;
    logic              send;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic              clear_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign occupancy = state;

    // Without a skid entry the stage can only accept when main drains this cycle
    assign in_ready = SKID_EN ? rdy_q : (rdy_q && (out_ready || !out_valid));

    assign accept = in_valid && in_ready;
    assign send   = out_valid && out_ready;

    // Next-state and entry load decisions
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        clear_ctrl     = 1'b0;
        if (flush) begin
            state_nxt  = ST_EMPTY;
            clear_ctrl = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt    = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && send) begin
                        load_main_in = 1'b1;
                    end else if (accept && SKID_EN) begin
                        state_nxt = ST_FULL;
                        load_skid = 1'b1;
                    end else if (send) begin
                        state_nxt  = ST_EMPTY;
                        clear_ctrl = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (send) begin
                        state_nxt      = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt  = ST_EMPTY;
                    clear_ctrl = 1'b1;
                end
            endcase
        end
    end

    // State and registered ready; ready stays low until the first edge after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != ST_FULL);
        end
    end

    // Main entry: data is left stale when emptied, control returns to the bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_data <= '0;
            main_ctrl <= CTRL_RST;
        end else if (load_main_in) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
        end else if (load_main_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
        end else if (clear_ctrl) begin
            main_ctrl <= CTRL_RST;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_data <= '0;
            skid_ctrl <= CTRL_RST;
        end else if (load_skid) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: skid instance (a_*) and single-register
// instance (b_*, non-zero bubble encoding).
module tb_pipe_stage_elastic;

    localparam logic [7:0] B_CTRL_RST = 8'hA5;

    logic        clk;
    logic        reset;

    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [7:0]  a_in_ctrl, a_out_ctrl;
    logic [1:0]  a_occupancy;

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [7:0]  b_in_ctrl, b_out_ctrl;
    logic [1:0]  b_occupancy;

    int nvec = 0;
    int nerr = 0;

    pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .SKID_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .occupancy(a_occupancy)
    );

    pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .CTRL_RST(B_CTRL_RST), .SKID_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .occupancy(b_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [7:0]  c;
        logic        fl;
        logic        ordy;
        logic        ev;
        logic [31:0] ed;
        logic [7:0]  ec;
        logic [1:0]  eo;
        logic        er;
    } vec_t;

    vec_t tbl[13];

    logic [31:0] q_data[$];
    logic [7:0]  q_ctrl[$];
    bit          m_rdy;
    bit          m_send;
    bit          m_acc;

    initial begin
        // inputs: valid, data, ctrl, flush, out_ready | expected: valid, data, ctrl, occ, in_ready
        tbl[0]  = '{1'b1, 32'h11, 8'h11, 1'b0, 1'b0, 1'b1, 32'h11, 8'h11, 2'd1, 1'b1};
        tbl[1]  = '{1'b1, 32'h22, 8'h22, 1'b0, 1'b0, 1'b1, 32'h11, 8'h11, 2'd2, 1'b0};
        tbl[2]  = '{1'b1, 32'h99, 8'h99, 1'b0, 1'b0, 1'b1, 32'h11, 8'h11, 2'd2, 1'b0};
        tbl[3]  = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b1, 32'h22, 8'h22, 2'd1, 1'b1};
        tbl[4]  = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h22, 8'h00, 2'd0, 1'b1};
        tbl[5]  = '{1'b1, 32'h44, 8'h44, 1'b0, 1'b0, 1'b1, 32'h44, 8'h44, 2'd1, 1'b1};
        tbl[6]  = '{1'b1, 32'h55, 8'h55, 1'b0, 1'b0, 1'b1, 32'h44, 8'h44, 2'd2, 1'b0};
        tbl[7]  = '{1'b1, 32'h33, 8'h33, 1'b1, 1'b0, 1'b0, 32'h44, 8'h00, 2'd0, 1'b1};
        tbl[8]  = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h44, 8'h00, 2'd0, 1'b1};
        tbl[9]  = '{1'b1, 32'h66, 8'h66, 1'b0, 1'b1, 1'b1, 32'h66, 8'h66, 2'd1, 1'b1};
        tbl[10] = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h66, 8'h00, 2'd0, 1'b1};
        tbl[11] = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h66, 8'h00, 2'd0, 1'b1};
        tbl[12] = '{1'b1, 32'h77, 8'h77, 1'b1, 1'b1, 1'b0, 32'h66, 8'h00, 2'd0, 1'b1};

        reset       = 1'b0;
        a_in_valid  = 1'b1; a_in_data = 32'hDEAD_BEEF; a_in_ctrl = 8'hFF; a_flush = 1'b0; a_out_ready = 1'b0;
        b_in_valid  = 1'b1; b_in_data = 32'hDEAD_BEEF; b_in_ctrl = 8'hFF; b_flush = 1'b0; b_out_ready = 1'b0;

        // Reset held across edges with a beat presented
        step();
        step();
        chk("rst_a_valid", 64'(a_out_valid), 64'(0));
        chk("rst_a_ctrl",  64'(a_out_ctrl),  64'(0));
        chk("rst_a_data",  64'(a_out_data),  64'(0));
        chk("rst_a_occ",   64'(a_occupancy), 64'(0));
        chk("rst_a_ready", 64'(a_in_ready),  64'(0));
        chk("rst_b_ctrl",  64'(b_out_ctrl),  64'(B_CTRL_RST));
        chk("rst_b_ready", 64'(b_in_ready),  64'(0));

        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        reset      = 1'b1;
        #1;
        chk("rel_a_ready_pre", 64'(a_in_ready), 64'(0));
        step();
        chk("rel_a_ready", 64'(a_in_ready), 64'(1));
        chk("rel_b_ready", 64'(b_in_ready), 64'(1));
        chk("rel_a_valid", 64'(a_out_valid), 64'(0));

        // Table: backpressure, flush while FULL, flush with send
        for (int i = 0; i < 13; i++) begin
            a_in_valid  = tbl[i].iv;
            a_in_data   = tbl[i].d;
            a_in_ctrl   = tbl[i].c;
            a_flush     = tbl[i].fl;
            a_out_ready = tbl[i].ordy;
            step();
            chk($sformatf("tbl%0d_valid", i), 64'(a_out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i),  64'(a_out_data),  64'(tbl[i].ed));
            chk($sformatf("tbl%0d_ctrl", i),  64'(a_out_ctrl),  64'(tbl[i].ec));
            chk($sformatf("tbl%0d_occ", i),   64'(a_occupancy), 64'(tbl[i].eo));
            chk($sformatf("tbl%0d_ready", i), 64'(a_in_ready),  64'(tbl[i].er));
        end
        a_flush = 1'b0;

        // Streaming 1..8 with out_ready high
        a_out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'(k);
            a_in_ctrl  = 8'(k);
            step();
            chk($sformatf("strm%0d_data", k),  64'(a_out_data),  64'(k));
            chk($sformatf("strm%0d_valid", k), 64'(a_out_valid), 64'(1));
            chk($sformatf("strm%0d_occ", k),   64'(a_occupancy), 64'(1));
        end
        a_in_valid = 1'b0;
        step();
        chk("strm_end_valid", 64'(a_out_valid), 64'(0));
        chk("strm_end_occ",   64'(a_occupancy), 64'(0));

        // Single-register instance: in_ready follows out_ready within the cycle
        b_in_valid  = 1'b1; b_in_data = 32'h101; b_in_ctrl = 8'h01; b_out_ready = 1'b0;
        step();
        chk("b_hold_data",  64'(b_out_data),  64'(32'h101));
        chk("b_hold_occ",   64'(b_occupancy), 64'(1));
        chk("b_hold_ready", 64'(b_in_ready),  64'(0));
        b_in_data   = 32'h102; b_in_ctrl = 8'h02;
        b_out_ready = 1'b1;
        #1;
        chk("b_comb_ready", 64'(b_in_ready), 64'(1));
        for (int k = 2; k <= 6; k++) begin
            b_in_data = 32'h100 + 32'(k);
            b_in_ctrl = 8'(k);
            step();
            chk($sformatf("b_strm%0d_data", k), 64'(b_out_data),  64'(32'h100 + 32'(k)));
            chk($sformatf("b_strm%0d_occ", k),  64'(b_occupancy), 64'(1));
        end
        b_in_valid = 1'b0;
        step();
        chk("b_empty_valid", 64'(b_out_valid), 64'(0));
        chk("b_empty_ctrl",  64'(b_out_ctrl),  64'(B_CTRL_RST));

        // Randomized traffic against a queue model of the skid instance
        a_in_valid = 1'b0; a_flush = 1'b0;
        m_rdy = 1'b1;
        for (int i = 0; i < 600; i++) begin
            chk("rnd_valid", 64'(a_out_valid), 64'(q_data.size() != 0));
            chk("rnd_occ",   64'(a_occupancy), 64'(q_data.size()));
            chk("rnd_ready", 64'(a_in_ready),  64'(m_rdy));
            if (q_data.size() != 0) begin
                chk("rnd_data", 64'(a_out_data), 64'(q_data[0]));
                chk("rnd_ctrl", 64'(a_out_ctrl), 64'(q_ctrl[0]));
            end else begin
                chk("rnd_ctrl_bubble", 64'(a_out_ctrl), 64'(0));
            end
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_data   = $urandom;
            a_in_ctrl   = 8'($urandom);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_flush     = ($urandom_range(0, 19) == 0);
            m_send = (q_data.size() != 0) && a_out_ready;
            m_acc  = a_in_valid && m_rdy;
            step();
            if (m_send) begin
                void'(q_data.pop_front());
                void'(q_ctrl.pop_front());
            end
            if (a_flush) begin
                q_data.delete();
                q_ctrl.delete();
            end else if (m_acc) begin
                q_data.push_back(a_in_data);
                q_ctrl.push_back(a_in_ctrl);
            end
            m_rdy = (q_data.size() < 2);
        end
        a_flush = 1'b0;

        // Reset mid-transfer discards both held beats
        a_in_valid = 1'b1; a_out_ready = 1'b0; a_in_data = 32'hAAA1; a_in_ctrl = 8'hA1;
        step();
        a_in_data = 32'hAAA2; a_in_ctrl = 8'hA2;
        step();
        a_in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(a_out_valid), 64'(0));
        chk("mid_rst_occ",   64'(a_occupancy), 64'(0));
        chk("mid_rst_ready", 64'(a_in_ready),  64'(0));
        chk("mid_rst_ctrl",  64'(a_out_ctrl),  64'(0));
        step();
        reset = 1'b1;
        step();
        chk("post_rst_ready", 64'(a_in_ready), 64'(1));
        a_in_valid = 1'b1; a_in_data = 32'hBBB1; a_in_ctrl = 8'hB1; a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        chk("post_rst_data", 64'(a_out_data), 64'(32'hBBB1));
        chk("post_rst_occ",  64'(a_occupancy), 64'(1));
        step();
        chk("post_rst_drain", 64'(a_out_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
